shiftchain_master: RTL and testbench

- Initiator for the team's serial configuration shift chain.
- Serializes a command word into the chain's `s_in`, pulses `load` to commit it, and pulses `read` to snapshot the chain's parallel `r_read` inputs.
- Deserializes `s_out` back to a parallel word.
- Sits between the digital config/register interface and the chain instances in the PLL wrapper; shares `clk` with the chain.

---
 rtl/shiftchain_pkg.sv | 18 +
 rtl/shiftchain_if.sv | 26 ++
 rtl/shiftchain_bitctr.sv | 29 ++
 rtl/shiftchain_master.sv | 113 +++++++++++
 tb/tb_shiftchain_master.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shiftchain_pkg.sv
// Shared types and constants for the shift-chain initiator.
package shiftchain_pkg;

   localparam int N_DEFAULT = 32;

   localparam logic OP_WRITE = 1'b0;
   localparam logic OP_READ  = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      SNAP,
      SHIFT,
      LOAD,
      ECHO,
      RESP
   } state_t;

endpackage

// File: rtl/shiftchain_if.sv
// Command/response handshake between the config register side and the chain initiator.
interface shiftchain_if
   import shiftchain_pkg::*;
#(
   parameter int N = N_DEFAULT
);
   logic         cmd_valid;
   logic         cmd_ready;
   logic         cmd_op;
   logic [N-1:0] cmd_wdata;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [N-1:0] rsp_rdata;
   logic         rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_wdata, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_wdata, rsp_ready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/shiftchain_bitctr.sv
// Bit position counter 0..N-1 with terminal-count flag; shared by the SHIFT and ECHO phases.
module shiftchain_bitctr
   import shiftchain_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 en,
   output logic [$clog2(N)-1:0] count,
   output logic                 tc
);

   localparam int CNT_W = $clog2(N);

   assign tc = (count == CNT_W'(N - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= tc ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/shiftchain_master.sv
// Serial config chain initiator: shifts command words in LSB-first, pulses load/read, returns the shifted-out word.
// Optional echo read-back of every WRITE is compiled in with SHIFTCHAIN_ECHO_CHECK_EN.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for a command; chain free-shifts zeros
//   SNAP  | one cycle of chain_read, chain captures its r_read inputs
//   SHIFT | N cycles driving tx[i] (or 0) and capturing s_out into rx[i]
//   LOAD  | one cycle of chain_load, commits r_reg to chain outputs
//   ECHO  | N cycles re-shifting tx to read back what the chain holds
//   RESP  | response held until rsp_ready
module shiftchain_master
   import shiftchain_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   shiftchain_if.slave bus,
   output logic       busy,
   output logic       chain_s_in,
   output logic       chain_load,
   output logic       chain_read,
   input  logic       chain_s_out
);

   localparam int CNT_W = $clog2(N);

   state_t           state;
   state_t           state_nxt;
   logic             ready_en;
   logic             op;
   logic [N-1:0]     tx;
   logic [N-1:0]     rx;
   logic [CNT_W-1:0] bit_idx;
   logic             bit_tc;
   logic             ctr_clr;
   logic             ctr_en;
   logic             accept;
   logic             shifting;

   assign shifting = (state == SHIFT) || (state == ECHO);
   assign ctr_en   = shifting;
   assign accept   = bus.cmd_valid && bus.cmd_ready;

   shiftchain_bitctr #(.N(N)) u_bitctr (
      .clk   (clk),
      .reset (reset),
      .clear (ctr_clr),
      .en    (ctr_en),
      .count (bit_idx),
      .tc    (bit_tc)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         ready_en <= 1'b0;
         op       <= OP_WRITE;
         tx       <= '0;
         rx       <= '0;
      end else begin
         state    <= state_nxt;
         ready_en <= 1'b1;
         if (accept) begin
            op <= bus.cmd_op;
            tx <= (bus.cmd_op == OP_READ) ? '0 : bus.cmd_wdata;
         end
         if (shifting) begin
            rx[bit_idx] <= chain_s_out;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ctr_clr   = 1'b0;
      case (state)
         IDLE:  if (accept) state_nxt = (bus.cmd_op == OP_READ) ? SNAP : SHIFT;
         SNAP:  state_nxt = SHIFT;
         SHIFT: if (bit_tc) state_nxt = (op == OP_READ) ? RESP : LOAD;
`ifdef SHIFTCHAIN_ECHO_CHECK_EN
         LOAD:  state_nxt = ECHO;
         ECHO:  if (bit_tc) state_nxt = RESP;
`else
         LOAD:  state_nxt = RESP;
         ECHO:  state_nxt = IDLE;
`endif
         RESP:  if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // counter restarts from bit 0 whenever a serial phase begins
      if ((state_nxt == SHIFT && state != SHIFT) || (state_nxt == ECHO && state != ECHO)) begin
         ctr_clr = 1'b1;
      end
   end

   // ready_en keeps cmd_ready low while reset is held without a path from the reset pin
   assign bus.cmd_ready = (state == IDLE) && ready_en;
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_rdata = (state == RESP) ? rx : '0;
   assign busy          = (state != IDLE) && (state != RESP);
   assign chain_read    = (state == SNAP);
   assign chain_load    = (state == LOAD);
   assign chain_s_in    = shifting && tx[bit_idx];

`ifdef SHIFTCHAIN_ECHO_CHECK_EN
   assign bus.rsp_err = (state == RESP) && (op == OP_WRITE) && (rx != tx);
`else
   assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_shiftchain_master.sv
// Bench for shiftchain_master: behavioural N-bit chain model plus per-scenario checks.
module tb_shiftchain_master;
   import shiftchain_pkg::*;

   localparam int N = 32;
`ifdef SHIFTCHAIN_ECHO_CHECK_EN
   localparam int WR_LAT = 2*N + 2;
`else
   localparam int WR_LAT = N + 2;
`endif
   localparam int RD_LAT = N + 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic busy, chain_s_in, chain_load, chain_read, chain_s_out;

   shiftchain_if #(.N(N)) bus();

   shiftchain_master #(.N(N)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .busy        (busy),
      .chain_s_in  (chain_s_in),
      .chain_load  (chain_load),
      .chain_read  (chain_read),
      .chain_s_out (chain_s_out)
   );

   always #5 clk = ~clk;

   // chain model: r_reg shifts right with s_in entering at the MSB unless load/read
   logic [N-1:0] m_r = '0;
   logic [N-1:0] m_par = '0;
   logic [N-1:0] m_nxt;
   logic [N-1:0] r_read = '0;
   bit           stuck = 1'b0;
   bit           c_s_in = 1'b0, c_load = 1'b0, c_read = 1'b0;

   assign chain_s_out = m_r[0];

   always @(negedge clk) begin
      c_s_in = (chain_s_in === 1'b1);
      c_load = (chain_load === 1'b1);
      c_read = (chain_read === 1'b1);
   end

   always @(posedge clk) begin
      m_nxt = m_r;
      if (c_load)      m_par <= m_r;
      else if (c_read) m_nxt = r_read;
      else             m_nxt = {c_s_in, m_r[N-1:1]};
      if (stuck) m_nxt[5] = 1'b0;
      m_r <= m_nxt;
   end

   int n_checks = 0;
   int n_fail   = 0;

   // drives one command and collects what happened; called just after a negedge
   task automatic run_op(input logic op_i, input logic [N-1:0] wdata, input int hold,
                         output logic [N-1:0] rdata, output logic err, output int lat,
                         output int loads, output int load_cyc, output int reads,
                         output logic [N-1:0] prev, output bit timeout, output bit unstable);
      int cyc;
      int guard;
      timeout = 0; unstable = 0; loads = 0; reads = 0; load_cyc = -1; lat = -1;
      rdata = '0; err = 1'b0; prev = '0;
      bus.cmd_valid = 1'b1; bus.cmd_op = op_i; bus.cmd_wdata = wdata;
      guard = 0;
      while (bus.cmd_ready !== 1'b1 && guard < 100) begin
         @(negedge clk); guard++;
      end
      if (guard >= 100) begin
         timeout = 1; bus.cmd_valid = 1'b0; return;
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0; bus.cmd_wdata = $urandom;
      prev = m_r;
      cyc = 1;
      while (bus.rsp_valid !== 1'b1 && cyc < 200) begin
         if (chain_load === 1'b1) begin loads++; if (load_cyc < 0) load_cyc = cyc; end
         if (chain_read === 1'b1) reads++;
         @(negedge clk); cyc++;
      end
      if (cyc >= 200) begin
         timeout = 1; return;
      end
      lat = cyc; rdata = bus.rsp_rdata; err = bus.rsp_err;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== rdata || bus.rsp_err !== err ||
             chain_load !== 1'b0 || chain_read !== 1'b0) unstable = 1;
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
   endtask

   logic [N-1:0] o_rdata, o_prev, exp_word, par_before, word;
   logic         o_err, o_op;
   int           o_lat, o_loads, o_load_cyc, o_reads;
   bit           o_to, o_unst;

   function automatic logic [N+6:0] out_vec();
      return {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, busy, chain_s_in, chain_load, chain_read, bus.rsp_rdata};
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if (out_vec() !== '0) begin
            n_fail++; $display("FAIL reset_outputs cycle %0d: got %h expected 0", c, out_vec());
         end
      end
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_release: got ready=%b busy=%b valid=%b expected 1/0/0",
                            bus.cmd_ready, busy, bus.rsp_valid);
      end
   endtask

   task automatic test_write_basic();
      word = 32'hA5C3_0F81;
      run_op(OP_WRITE, word, 2, o_rdata, o_err, o_lat, o_loads, o_load_cyc, o_reads, o_prev, o_to, o_unst);
      n_checks++;
      if (o_to) begin n_fail++; $display("FAIL write_basic_timeout: got timeout expected response"); end
      n_checks++;
      if (o_loads !== 1 || o_load_cyc !== N + 1) begin
         n_fail++; $display("FAIL write_load_pulse: got count=%0d cycle=%0d expected 1 at %0d", o_loads, o_load_cyc, N + 1);
      end
      n_checks++;
      if (m_par !== word) begin n_fail++; $display("FAIL write_par_out: got %h expected %h", m_par, word); end
`ifdef SHIFTCHAIN_ECHO_CHECK_EN
      exp_word = word;
`else
      exp_word = 32'h0000_0000;
`endif
      n_checks++;
      if (o_rdata !== exp_word) begin n_fail++; $display("FAIL write_rdata: got %h expected %h", o_rdata, exp_word); end
      n_checks++;
      if (o_lat !== WR_LAT) begin n_fail++; $display("FAIL write_latency: got %0d expected %0d", o_lat, WR_LAT); end
      n_checks++;
      if (o_err !== 1'b0 || o_unst) begin n_fail++; $display("FAIL write_err_stable: got err=%b unstable=%0d expected 0/0", o_err, o_unst); end
   endtask

   task automatic test_full_duplex();
      word = 32'h1234_5678;
      run_op(OP_WRITE, word, 0, o_rdata, o_err, o_lat, o_loads, o_load_cyc, o_reads, o_prev, o_to, o_unst);
`ifdef SHIFTCHAIN_ECHO_CHECK_EN
      exp_word = word;
`else
      exp_word = o_prev;
`endif
      n_checks++;
      if (o_to || o_rdata !== exp_word) begin
         n_fail++; $display("FAIL full_duplex_rdata: got %h expected %h (timeout=%0d)", o_rdata, exp_word, o_to);
      end
      n_checks++;
      if (m_par !== word) begin n_fail++; $display("FAIL full_duplex_par: got %h expected %h", m_par, word); end
   endtask

   task automatic test_read();
      r_read = 32'hDEAD_BEEF;
      par_before = m_par;
      run_op(OP_READ, 32'hFFFF_FFFF, 1, o_rdata, o_err, o_lat, o_loads, o_load_cyc, o_reads, o_prev, o_to, o_unst);
      n_checks++;
      if (o_to || o_rdata !== r_read) begin n_fail++; $display("FAIL read_rdata: got %h expected %h", o_rdata, r_read); end
      n_checks++;
      if (o_reads !== 1 || o_loads !== 0) begin
         n_fail++; $display("FAIL read_pulses: got read=%0d load=%0d expected 1/0", o_reads, o_loads);
      end
      n_checks++;
      if (m_par !== par_before) begin n_fail++; $display("FAIL read_par_unchanged: got %h expected %h", m_par, par_before); end
      n_checks++;
      if (o_lat !== RD_LAT || o_err !== 1'b0) begin
         n_fail++; $display("FAIL read_latency: got %0d err=%b expected %0d err=0", o_lat, o_err, RD_LAT);
      end
   endtask

   task automatic test_backpressure();
      int guard;
      logic [N-1:0] held;
      word = $urandom;
      bus.cmd_valid = 1'b1; bus.cmd_op = OP_WRITE; bus.cmd_wdata = word;
      guard = 0;
      while (bus.cmd_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
      @(negedge clk);
      o_prev = m_r;
      bus.cmd_wdata = ~word;
      guard = 0;
      while (bus.rsp_valid !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
      n_checks++;
      if (guard >= 200) begin n_fail++; $display("FAIL backpressure_timeout: got no rsp_valid expected response"); end
`ifdef SHIFTCHAIN_ECHO_CHECK_EN
      exp_word = word;
`else
      exp_word = o_prev;
`endif
      held = bus.rsp_rdata;
      n_checks++;
      if (held !== exp_word) begin n_fail++; $display("FAIL backpressure_rdata: got %h expected %h", held, exp_word); end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== held || bus.cmd_ready !== 1'b0 ||
             chain_load !== 1'b0 || chain_read !== 1'b0 || chain_s_in !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_hold cycle %0d: got valid=%b rdata=%h ready=%b load=%b read=%b s_in=%b busy=%b expected 1/%h/0/0/0/0/0",
                     c, bus.rsp_valid, bus.rsp_rdata, bus.cmd_ready, chain_load, chain_read, chain_s_in, busy, held);
         end
      end
      n_checks++;
      if (m_par !== word) begin n_fail++; $display("FAIL backpressure_par: got %h expected %h", m_par, word); end
      bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      n_checks++;
      if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL backpressure_release: got ready=%b valid=%b expected 1/0", bus.cmd_ready, bus.rsp_valid);
      end
   endtask

   task automatic test_reset_mid();
      int guard;
      bit seen;
      par_before = m_par;
      bus.cmd_valid = 1'b1; bus.cmd_op = OP_WRITE; bus.cmd_wdata = $urandom;
      guard = 0;
      while (bus.cmd_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (7) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_mid_busy: got %b expected 1", busy); end
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_vec() !== '0) begin n_fail++; $display("FAIL reset_mid_outputs: got %h expected 0", out_vec()); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_ready: got %b expected 1", bus.cmd_ready); end
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         if (bus.rsp_valid !== 1'b0 || chain_load !== 1'b0) seen = 1;
         @(negedge clk);
      end
      n_checks++;
      if (seen || m_par !== par_before) begin
         n_fail++; $display("FAIL reset_mid_no_response: got activity=%0d par=%h expected 0 par=%h", seen, m_par, par_before);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 10; it++) begin
         o_op = 1'($urandom_range(0, 1));
         word = $urandom;
         if (o_op == OP_READ) r_read = $urandom;
         par_before = m_par;
         run_op(o_op, word, int'($urandom_range(0, 3)), o_rdata, o_err, o_lat, o_loads, o_load_cyc, o_reads, o_prev, o_to, o_unst);
`ifdef SHIFTCHAIN_ECHO_CHECK_EN
         exp_word = (o_op == OP_READ) ? r_read : word;
`else
         exp_word = (o_op == OP_READ) ? r_read : o_prev;
`endif
         n_checks++;
         if (o_to || o_rdata !== exp_word || o_unst) begin
            n_fail++; $display("FAIL random_rdata it=%0d op=%b: got %h expected %h (timeout=%0d unstable=%0d)",
                               it, o_op, o_rdata, exp_word, o_to, o_unst);
         end
         n_checks++;
         if (o_lat !== ((o_op == OP_READ) ? RD_LAT : WR_LAT)) begin
            n_fail++; $display("FAIL random_latency it=%0d op=%b: got %0d expected %0d", it, o_op, o_lat,
                               (o_op == OP_READ) ? RD_LAT : WR_LAT);
         end
         n_checks++;
         if (m_par !== ((o_op == OP_READ) ? par_before : word) || o_loads !== ((o_op == OP_READ) ? 0 : 1)) begin
            n_fail++; $display("FAIL random_par it=%0d op=%b: got %h loads=%0d expected %h", it, o_op, m_par, o_loads,
                               (o_op == OP_READ) ? par_before : word);
         end
      end
   endtask

`ifdef SHIFTCHAIN_ECHO_CHECK_EN
   task automatic test_echo();
      word = 32'hFFFF_0000;
      run_op(OP_WRITE, word, 1, o_rdata, o_err, o_lat, o_loads, o_load_cyc, o_reads, o_prev, o_to, o_unst);
      n_checks++;
      if (o_to || o_err !== 1'b0 || o_rdata !== word) begin
         n_fail++; $display("FAIL echo_clean: got err=%b rdata=%h expected err=0 rdata=%h", o_err, o_rdata, word);
      end
      n_checks++;
      if (m_par !== word || o_lat !== 2*N + 2) begin
         n_fail++; $display("FAIL echo_par_latency: got par=%h lat=%0d expected %h %0d", m_par, o_lat, word, 2*N + 2);
      end
      stuck = 1'b1;
      word = $urandom | 32'h0000_0020;
      run_op(OP_WRITE, word, 0, o_rdata, o_err, o_lat, o_loads, o_load_cyc, o_reads, o_prev, o_to, o_unst);
      stuck = 1'b0;
      n_checks++;
      if (o_to || o_err !== 1'b1) begin n_fail++; $display("FAIL echo_stuck_bit: got err=%b expected 1", o_err); end
   endtask
`endif

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_op = OP_WRITE; bus.cmd_wdata = '0; bus.rsp_ready = 1'b0;
      reset = 1'b0;
      test_reset();
      test_write_basic();
      test_full_duplex();
      test_read();
      test_backpressure();
      test_reset_mid();
      test_random();
`ifdef SHIFTCHAIN_ECHO_CHECK_EN
      test_echo();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
